ps2_cmd_ctrl: RTL
=================

PS2_CMD_CTRL -- requirements
Module: ps2_cmd_ctrl

Interface
REQ-001 SHALL provide parameter TIMEOUT_CYC, default 500000, meaning clk cycles allowed per response wait (10 ms at 50 MHz).
REQ-002 SHALL provide parameter MAX_RETRY, default 3, meaning resends permitted per command byte after 8'hFE.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 init_req  input  1  one-cycle pulse: issue keyboard reset (8'hFF).
REQ-006 led_req  input  1  one-cycle pulse: issue set-LED (8'hED + argument).
REQ-007 led_val  input  3  LED argument {caps, num, scroll}, sampled with led_req.
REQ-008 rx_valid  input  1  one-cycle strobe: received byte available.
REQ-009 rx_byte  input  8  received keyboard byte.
REQ-010 tx_busy  input  1  transmitter busy; high from cycle after tx_start until byte sent.
REQ-011 tx_start  output  1  one-cycle pulse: transmit tx_byte.
REQ-012 tx_byte  output  8  byte to transmit; stable from tx_start until tx_busy falls.
REQ-013 key_valid  output  1  one-cycle strobe: forwarded scan byte.
REQ-014 key_byte  output  8  forwarded scan byte.
REQ-015 busy  output  1  high whenever state is not IDLE.
REQ-016 done  output  1  one-cycle pulse: command sequence completed.
REQ-017 err  output  1  one-cycle pulse: command sequence aborted.
REQ-018 err_code  output  2  cause, held until next err: 1 timeout, 2 retries exhausted, 3 self-test fail (8'hFC).

Function
REQ-019 States SHALL be IDLE, SEND_CMD, WAIT_TX1, WAIT_ACK1, SEND_ARG, WAIT_TX2, WAIT_ACK2, WAIT_BAT.
REQ-020 IDLE: init_req -> SEND_CMD with cmd 8'hFF; else led_req -> SEND_CMD with cmd 8'hED, latch led_val; both same cycle -> init wins, led request latched as pending.
REQ-021 SEND_CMD/SEND_ARG: assert tx_start one cycle only when tx_busy low; otherwise hold state; next state WAIT_TX1/WAIT_TX2.
REQ-022 WAIT_TXn: wait for tx_busy falling (high then low), then WAIT_ACKn with timeout counter cleared.
REQ-023 WAIT_ACKn: rx_valid with 8'hFA -> ack; 8'hFE -> resend same byte (back to SEND_CMD/SEND_ARG) and increment retry count; any other byte -> forwarded, state unchanged.
REQ-024 Ack in WAIT_ACK1: cmd FF -> WAIT_BAT; cmd ED -> SEND_ARG with tx_byte {5'b0, led_val}. Ack in WAIT_ACK2 -> done pulse, IDLE.
REQ-025 WAIT_BAT: 8'hAA -> done, IDLE; 8'hFC -> err, err_code 3, IDLE; other bytes forwarded.
REQ-026 Retry count SHALL reset on every ack and on entry from IDLE; FE received when count equals MAX_RETRY -> err, err_code 2, IDLE.
REQ-027 Timeout counter SHALL increment each cycle in WAIT_ACKn/WAIT_BAT/WAIT_TXn, clear on state change; reaching TIMEOUT_CYC-1 -> err, err_code 1, IDLE.
REQ-028 Bytes 8'hFA, 8'hFE, 8'hAA, 8'hFC received in a wait state SHALL be consumed, not forwarded; in IDLE/SEND/WAIT_TX all rx bytes SHALL be forwarded.
REQ-029 Forwarding latency SHALL be one cycle: key_valid/key_byte registered from rx_valid/rx_byte.
REQ-030 led_req while busy SHALL set pending flag and overwrite latched led_val (latest wins); init_req while busy SHALL be ignored.
REQ-031 Pending LED request SHALL start from IDLE the cycle after done or err, then clear.
REQ-032 done and err SHALL never assert in the same cycle.

Reset
REQ-033 rst SHALL force IDLE mid-operation, discard pending request, clear counters; tx_start, key_valid, done, err, busy = 0; tx_byte, key_byte = 8'h00; err_code = 0.
REQ-034 First request SHALL be accepted the cycle after rst deasserts.

Verification
REQ-035 led_req, led_val=3'b101; model acks FA, FA -> tx bytes ED then 05, one done pulse, busy low after.
REQ-036 init_req; acks FA then AA -> done; repeat with FC -> err, err_code=3.
REQ-037 led_req; reply FE four times (MAX_RETRY=3) -> ED sent 4 times, err, err_code=2.
REQ-038 led_req, no reply, TIMEOUT_CYC=100 -> err, err_code=1 exactly 100 cycles after entering WAIT_ACK1.
REQ-039 Scan byte 8'h1C during WAIT_ACK1 -> key_valid with 8'h1C next cycle, state unchanged; FA not forwarded.
REQ-040 init_req+led_req same cycle -> FF sequence first, then ED sequence; rst during WAIT_ACK2 -> IDLE, no done, no pending.

Source files
------------

// File: rtl/ps2_cmd_ctrl.sv
// PS/2 keyboard command sequencer: issues reset (FF) and set-LED (ED + arg),
// handles FA/FE/AA/FC responses with resend and timeout, forwards scan bytes.
module ps2_cmd_ctrl #(
   parameter int TIMEOUT_CYC = 500000,
   parameter int MAX_RETRY   = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       init_req,
   input  logic       led_req,
   input  logic [2:0] led_val,
   input  logic       rx_valid,
   input  logic [7:0] rx_byte,
   input  logic       tx_busy,
   output logic       tx_start,
   output logic [7:0] tx_byte,
   output logic       key_valid,
   output logic [7:0] key_byte,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [1:0] err_code
);

   localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   typedef enum logic [2:0] {
      IDLE, SEND_CMD, WAIT_TX1, WAIT_ACK1, SEND_ARG, WAIT_TX2, WAIT_ACK2, WAIT_BAT
   } state_t;

   state_t          state, state_nxt;
   logic            cmd_init;
   logic [2:0]      led_lat;
   logic            pend;
   logic [RW-1:0]   retry;
   logic [TW-1:0]   to_cnt;
   logic            seen_busy;

   logic fin_done, fin_err, load_cmd, load_arg, retry_clr, retry_inc;
   logic [1:0] fin_code;

   logic rx_fa, rx_fe, rx_aa, rx_fc, in_wait, consume, timed_out, counting;

   assign rx_fa     = rx_valid && (rx_byte == 8'hFA);
   assign rx_fe     = rx_valid && (rx_byte == 8'hFE);
   assign rx_aa     = rx_valid && (rx_byte == 8'hAA);
   assign rx_fc     = rx_valid && (rx_byte == 8'hFC);
   assign in_wait   = (state == WAIT_ACK1) || (state == WAIT_ACK2) || (state == WAIT_BAT);
   assign consume   = in_wait && (rx_fa || rx_fe || rx_aa || rx_fc);
   assign timed_out = (to_cnt == TW'(TIMEOUT_CYC - 1));
   assign counting  = in_wait || (state == WAIT_TX1) || (state == WAIT_TX2);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      fin_done  = 1'b0;
      fin_err   = 1'b0;
      fin_code  = err_code;
      load_cmd  = 1'b0;
      load_arg  = 1'b0;
      retry_clr = 1'b0;
      retry_inc = 1'b0;
      case (state)
         IDLE: begin
            if (init_req || led_req || pend) begin
               state_nxt = SEND_CMD;
               load_cmd  = 1'b1;
               retry_clr = 1'b1;
            end
         end
         SEND_CMD: if (!tx_busy) state_nxt = WAIT_TX1;
         SEND_ARG: if (!tx_busy) state_nxt = WAIT_TX2;
         WAIT_TX1, WAIT_TX2: begin
            if (timed_out) begin
               fin_err = 1'b1; fin_code = 2'd1; state_nxt = IDLE;
            end else if (seen_busy && !tx_busy) begin
               state_nxt = (state == WAIT_TX1) ? WAIT_ACK1 : WAIT_ACK2;
            end
         end
         WAIT_ACK1, WAIT_ACK2: begin
            if (rx_fa) begin
               retry_clr = 1'b1;
               if (state == WAIT_ACK2) begin
                  fin_done = 1'b1; state_nxt = IDLE;
               end else if (cmd_init) begin
                  state_nxt = WAIT_BAT;
               end else begin
                  state_nxt = SEND_ARG; load_arg = 1'b1;
               end
            end else if (rx_fe) begin
               if (retry == RW'(MAX_RETRY)) begin
                  fin_err = 1'b1; fin_code = 2'd2; state_nxt = IDLE;
               end else begin
                  retry_inc = 1'b1;
                  state_nxt = (state == WAIT_ACK1) ? SEND_CMD : SEND_ARG;
               end
            end else if (timed_out) begin
               fin_err = 1'b1; fin_code = 2'd1; state_nxt = IDLE;
            end
         end
         WAIT_BAT: begin
            if (rx_aa) begin
               fin_done = 1'b1; state_nxt = IDLE;
            end else if (rx_fc) begin
               fin_err = 1'b1; fin_code = 2'd3; state_nxt = IDLE;
            end else if (timed_out) begin
               fin_err = 1'b1; fin_code = 2'd1; state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      tx_start = !rst && ((state == SEND_CMD) || (state == SEND_ARG)) && !tx_busy;
      busy     = (state != IDLE);
   end

   // A led_req coinciding with an accepted init, or arriving while busy, is held as pending.
   always_ff @(posedge clk) begin
      if (rst) begin
         cmd_init  <= 1'b0;
         led_lat   <= 3'b000;
         pend      <= 1'b0;
         retry     <= '0;
         to_cnt    <= '0;
         seen_busy <= 1'b0;
         tx_byte   <= 8'h00;
         key_valid <= 1'b0;
         key_byte  <= 8'h00;
         done      <= 1'b0;
         err       <= 1'b0;
         err_code  <= 2'd0;
      end else begin
         if (load_cmd) begin
            cmd_init <= init_req;
            tx_byte  <= init_req ? 8'hFF : 8'hED;
         end else if (load_arg) begin
            tx_byte <= {5'b00000, led_lat};
         end
         if (led_req) led_lat <= led_val;
         if (state == IDLE) pend <= init_req && (pend || led_req);
         else if (led_req)  pend <= 1'b1;
         if (retry_clr)      retry <= '0;
         else if (retry_inc) retry <= retry + RW'(1);
         if (state_nxt != state) begin
            to_cnt    <= '0;
            seen_busy <= 1'b0;
         end else begin
            if (counting) to_cnt <= to_cnt + TW'(1);
            if (((state == WAIT_TX1) || (state == WAIT_TX2)) && tx_busy) seen_busy <= 1'b1;
         end
         key_valid <= rx_valid && !consume;
         if (rx_valid && !consume) key_byte <= rx_byte;
         done <= fin_done;
         err  <= fin_err;
         if (fin_err) err_code <= fin_code;
      end
   end

endmodule
